// File: rtl/regalu_pkg.sv
// Shared types and constants for the register-file + ALU instruction sequencer.
package regalu_pkg;

  localparam int unsigned OPCODE_W = 2;

  // Default instruction layout (ADDR_W=5, SEL_W=3): {opcode, alu_sel, dst, srcA, srcB}
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_SEL_W  = 3;
  localparam int unsigned SRCB_LSB   = 0;
  localparam int unsigned SRCA_LSB   = DEF_ADDR_W;
  localparam int unsigned DST_LSB    = 2 * DEF_ADDR_W;
  localparam int unsigned SEL_LSB    = 3 * DEF_ADDR_W;
  localparam int unsigned OP_LSB     = SEL_LSB + DEF_SEL_W;
  localparam int unsigned INSTR_W    = OP_LSB + OPCODE_W;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP  = 2'b00,
    OP_ALU  = 2'b01,
    OP_HALT = 2'b10,
    OP_RSVD = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_HALTED
  } state_e;

  localparam logic [DEF_SEL_W-1:0] ALU_PASS_A = 3'd0;
  localparam logic [DEF_SEL_W-1:0] ALU_ADD    = 3'd1;
  localparam logic [DEF_SEL_W-1:0] ALU_SUB    = 3'd2;
  localparam logic [DEF_SEL_W-1:0] ALU_AND    = 3'd3;
  localparam logic [DEF_SEL_W-1:0] ALU_OR     = 3'd4;
  localparam logic [DEF_SEL_W-1:0] ALU_XOR    = 3'd5;
  localparam logic [DEF_SEL_W-1:0] ALU_NOT_A  = 3'd6;
  localparam logic [DEF_SEL_W-1:0] ALU_PASS_B = 3'd7;

  function automatic int unsigned instr_width(input int unsigned addr_w, input int unsigned sel_w);
    return OPCODE_W + sel_w + 3 * addr_w;
  endfunction

endpackage

// File: rtl/regalu_instr_decode.sv
// Combinational instruction field split and opcode classification.
module regalu_instr_decode
  import regalu_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned SEL_W  = 3
) (
  input  logic [instr_width(ADDR_W, SEL_W)-1:0] instr,
  output logic [SEL_W-1:0]                      alu_sel,
  output logic [ADDR_W-1:0]                     dst,
  output logic [ADDR_W-1:0]                     src_a,
  output logic [ADDR_W-1:0]                     src_b,
  output logic                                  is_alu,
  output logic                                  is_halt,
  output logic                                  is_illegal
);

  localparam int unsigned B_LSB   = 0;
  localparam int unsigned A_LSB   = ADDR_W;
  localparam int unsigned D_LSB   = 2 * ADDR_W;
  localparam int unsigned S_LSB   = 3 * ADDR_W;
  localparam int unsigned OPC_LSB = S_LSB + SEL_W;

  opcode_e opcode;

  assign opcode     = opcode_e'(instr[OPC_LSB +: OPCODE_W]);
  assign alu_sel    = instr[S_LSB +: SEL_W];
  assign dst        = instr[D_LSB +: ADDR_W];
  assign src_a      = instr[A_LSB +: ADDR_W];
  assign src_b      = instr[B_LSB +: ADDR_W];
  assign is_alu     = (opcode == OP_ALU);
  assign is_halt    = (opcode == OP_HALT);
  assign is_illegal = (opcode == OP_RSVD);

endmodule

// File: rtl/regalu_sequencer.sv
// Instruction sequencer: accepts one instruction, drives RF read/ALU select, then one write cycle.
module regalu_sequencer
  import regalu_pkg::*;
#(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned COUNT_W    = 16,
  parameter bit          PROTECT_R0 = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  instr_valid,
  output logic                                  instr_ready,
  input  logic [instr_width(ADDR_W, SEL_W)-1:0] instr,
  output logic                                  RF_W_en,
  output logic [ADDR_W-1:0]                     RF_W_addr,
  output logic [ADDR_W-1:0]                     RF_Ra_addr,
  output logic [ADDR_W-1:0]                     RF_Rb_addr,
  output logic [SEL_W-1:0]                      ALU_sel,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  halted,
  output logic                                  illegal,
  output logic [COUNT_W-1:0]                    instr_count
);

  state_e              state, state_nx;
  logic [SEL_W-1:0]    dec_sel;
  logic [ADDR_W-1:0]   dec_dst, dec_a, dec_b;
  logic                is_alu, is_halt, is_illegal, accept;

  logic                ready_nx, we_nx, busy_nx, done_nx, halted_nx, illegal_nx;
  logic [ADDR_W-1:0]   wa_nx, ra_nx, rb_nx;
  logic [SEL_W-1:0]    sel_nx;
  logic [COUNT_W-1:0]  count_nx;

  regalu_instr_decode #(.ADDR_W(ADDR_W), .SEL_W(SEL_W)) u_decode (
    .instr      (instr),
    .alu_sel    (dec_sel),
    .dst        (dec_dst),
    .src_a      (dec_a),
    .src_b      (dec_b),
    .is_alu     (is_alu),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  assign accept = instr_valid && instr_ready && (state == S_IDLE);

  // Outputs are registered alongside the state; the comb blocks compute their next values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      instr_ready <= 1'b1;
      RF_W_en     <= 1'b0;
      RF_W_addr   <= '0;
      RF_Ra_addr  <= '0;
      RF_Rb_addr  <= '0;
      ALU_sel     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state       <= state_nx;
      instr_ready <= ready_nx;
      RF_W_en     <= we_nx;
      RF_W_addr   <= wa_nx;
      RF_Ra_addr  <= ra_nx;
      RF_Rb_addr  <= rb_nx;
      ALU_sel     <= sel_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      halted      <= halted_nx;
      illegal     <= illegal_nx;
      instr_count <= count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (accept && is_alu)       state_nx = S_READ;
        else if (accept && is_halt) state_nx = S_HALTED;
      end
      S_READ:   state_nx = S_WRITE;
      S_WRITE:  state_nx = S_IDLE;
      S_HALTED: state_nx = S_HALTED;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ready_nx   = (state_nx == S_IDLE);
    busy_nx    = (state_nx == S_READ) || (state_nx == S_WRITE);
    halted_nx  = (state_nx == S_HALTED);
    we_nx      = 1'b0;
    done_nx    = 1'b0;
    wa_nx      = RF_W_addr;
    ra_nx      = RF_Ra_addr;
    rb_nx      = RF_Rb_addr;
    sel_nx     = ALU_sel;
    illegal_nx = illegal;
    count_nx   = instr_count;

    if (accept) begin
      if (is_alu) begin
        wa_nx  = dec_dst;
        ra_nx  = dec_a;
        rb_nx  = dec_b;
        sel_nx = dec_sel;
      end else begin
        // NOP/reserved retire now with a done pulse; HALT retires silently.
        count_nx = instr_count + COUNT_W'(1);
        done_nx  = !is_halt;
      end
      if (is_illegal) illegal_nx = 1'b1;
    end

    if (state == S_READ)
      we_nx = !(PROTECT_R0 && (RF_W_addr == '0));

    if (state == S_WRITE) begin
      done_nx  = 1'b1;
      count_nx = instr_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regalu_sequencer.sv
// Scoreboard bench for regalu_sequencer with a behavioural register file and ALU.
module tb_regalu_sequencer;
  import regalu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [19:0] instr = '0;
  logic        RF_W_en;
  logic [4:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr;
  logic [2:0]  ALU_sel;
  logic        busy, done, halted, illegal;
  logic [3:0]  instr_count;

  regalu_sequencer #(
    .ADDR_W(5), .SEL_W(3), .COUNT_W(4), .PROTECT_R0(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .RF_W_en(RF_W_en), .RF_W_addr(RF_W_addr), .RF_Ra_addr(RF_Ra_addr),
    .RF_Rb_addr(RF_Rb_addr), .ALU_sel(ALU_sel), .busy(busy), .done(done),
    .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Register file and ALU environment; rf[i] starts at 0x0100+i.
  logic [15:0] rf [32];
  logic        rf_loaded = 1'b0;
  logic [15:0] alu_y;

  function automatic logic [15:0] alu(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
    case (s)
      3'd0: return a;
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      3'd6: return ~a;
      default: return b;
    endcase
  endfunction

  assign alu_y = alu(ALU_sel, rf[RF_Ra_addr], rf[RF_Rb_addr]);

  always @(posedge clk) begin
    if (!rf_loaded) begin
      for (int i = 0; i < 32; i++) rf[i] <= 16'h0100 + 16'(i);
      rf_loaded <= 1'b1;
    end else if (RF_W_en) begin
      rf[RF_W_addr] <= alu_y;
    end
  end

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  typedef struct packed { logic [4:0] addr; logic [15:0] data; } wr_t;
  typedef struct packed { logic [3:0] cnt; logic ill; } dn_t;

  wr_t         exp_wr[$];
  dn_t         exp_dn[$];
  int unsigned wr_events = 0;
  logic [3:0]  exp_cnt = '0;
  logic        exp_ill = 1'b0;

  // Monitor: every write and every done pulse must match the next queued expectation.
  always @(negedge clk) begin : monitor
    wr_t we_exp;
    dn_t dn_exp;
    if (RF_W_en) begin
      wr_events++;
      if (exp_wr.size() == 0) check("unexpected_write", 32'(RF_W_addr), 32'hFFFF_FFFF);
      else begin
        we_exp = exp_wr.pop_front();
        check("wr_addr", 32'(RF_W_addr), 32'(we_exp.addr));
        check("wr_data", 32'(alu_y), 32'(we_exp.data));
      end
    end
    if (done) begin
      if (exp_dn.size() == 0) check("unexpected_done", 32'(instr_count), 32'hFFFF_FFFF);
      else begin
        dn_exp = exp_dn.pop_front();
        check("done_count", 32'(instr_count), 32'(dn_exp.cnt));
        check("done_illegal", 32'(illegal), 32'(dn_exp.ill));
      end
    end
  end

  function automatic logic [19:0] mk(input logic [1:0] op, input logic [2:0] s,
                                      input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    return {op, s, d, a, b};
  endfunction

  task automatic do_reset();
    instr_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_outs", 32'({RF_W_en, busy, done, halted, illegal, instr_count,
                           RF_W_addr, RF_Ra_addr, RF_Rb_addr, ALU_sel}), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_cnt = '0;
    exp_ill = 1'b0;
  endtask

  // Presents an instruction and returns #1 after the accepting edge; valid stays high.
  task automatic send(input logic [19:0] ins);
    int unsigned n;
    n = 0;
    instr = ins;
    instr_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_ready && n < 20);
    if (!instr_ready) check("accept_timeout", 32'(instr_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_alu(input logic [2:0] s, input logic [4:0] d, input logic [4:0] a,
                          input logic [4:0] b, input logic [15:0] data);
    if (d != 5'd0) exp_wr.push_back('{addr: d, data: data});
    exp_cnt = exp_cnt + 4'd1;
    exp_dn.push_back('{cnt: exp_cnt, ill: exp_ill});
    send(mk(OP_ALU, s, d, a, b));
  endtask

  task automatic send_nop(input logic [1:0] op);
    if (op == OP_RSVD) exp_ill = 1'b1;
    exp_cnt = exp_cnt + 4'd1;
    exp_dn.push_back('{cnt: exp_cnt, ill: exp_ill});
    send(mk(op, 3'd5, 5'd9, 5'd10, 5'd11));
  endtask

  task automatic idle(input int unsigned cycles);
    instr_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  time         t_a, t_b;
  int unsigned w0;

  initial begin
    #2;
    do_reset();

    // Single ALU instruction: latency and routing
    send_alu(ALU_ADD, 5'd3, 5'd1, 5'd2, 16'h0203);
    instr_valid = 1'b0;
    check("t0_ra", 32'(RF_Ra_addr), 32'd1);
    check("t0_rb", 32'(RF_Rb_addr), 32'd2);
    check("t0_sel", 32'(ALU_sel), 32'd1);
    check("t0_we_busy_ready", 32'({RF_W_en, busy, instr_ready}), 32'b010);
    @(posedge clk); #1;
    check("t1_we_addr", 32'({RF_W_en, RF_W_addr}), 32'({1'b1, 5'd3}));
    @(posedge clk); #1;
    check("t2_we_done_ready", 32'({RF_W_en, done, instr_ready}), 32'b011);
    check("t2_count", 32'(instr_count), 32'd1);
    check("rf3", 32'(rf[3]), 32'h0203);
    idle(2);

    // Back-to-back with valid held: NOP, ALU to r5, dependent ALU reading r5
    do_reset();
    send_nop(OP_NOP);
    check("nop_ready_held", 32'(instr_ready), 32'd1);
    send_alu(ALU_ADD, 5'd5, 5'd1, 5'd2, 16'h0203);
    t_a = $time;
    send_alu(ALU_SUB, 5'd6, 5'd5, 5'd4, 16'h00FF);
    t_b = $time;
    check("alu_throughput", 32'(t_b - t_a), 32'd30);
    idle(5);
    check("b2b_count", 32'(instr_count), 32'd3);
    check("rf6", 32'(rf[6]), 32'h00FF);

    // Write to r0 suppressed, still retires
    do_reset();
    w0 = wr_events;
    send_alu(ALU_ADD, 5'd0, 5'd1, 5'd2, 16'h0000);
    idle(5);
    check("r0_no_write", 32'(wr_events - w0), 32'd0);
    check("r0_count", 32'(instr_count), 32'd1);
    check("rf0", 32'(rf[0]), 32'h0100);

    // Reserved opcode, then HALT
    do_reset();
    send_nop(OP_RSVD);
    send_nop(OP_NOP);
    send(mk(OP_HALT, 3'd0, 5'd0, 5'd0, 5'd0));
    check("halt_flags", 32'({halted, instr_ready, busy, illegal}), 32'b1001);
    check("halt_count", 32'(instr_count), 32'd3);
    instr = mk(OP_ALU, ALU_ADD, 5'd8, 5'd1, 5'd2);
    repeat (6) @(posedge clk);
    #1;
    check("halted_hold", 32'({halted, instr_ready, busy, illegal}), 32'b1001);
    check("halted_count", 32'(instr_count), 32'd3);
    idle(1);

    // Reset during WRITE: write lost, no done, count cleared
    do_reset();
    send(mk(OP_ALU, ALU_ADD, 5'd7, 5'd1, 5'd2));
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_write_we", 32'(RF_W_en), 32'd1);
    reset = 1'b1;
    #1;
    check("reset_we_drop", 32'({RF_W_en, done, busy, instr_ready}), 32'b0001);
    check("reset_count", 32'(instr_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_cnt = '0;
    exp_ill = 1'b0;
    idle(3);
    check("rf7_unchanged", 32'(rf[7]), 32'h0107);
    check("post_reset_count", 32'(instr_count), 32'd0);

    // 16 NOPs wrap the 4-bit count back to 0
    do_reset();
    for (int i = 0; i < 16; i++) send_nop(OP_NOP);
    idle(3);
    check("wrap_count", 32'(instr_count), 32'd0);

    idle(2);
    check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    check("done_queue_drained", 32'(exp_dn.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
